// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: host op codes, master FSM states, TAP instruction
// set and capture constants, and the per-op TMS walk tables.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'b00,
    OP_SHIFT_IR = 2'b01,
    OP_SHIFT_DR = 2'b10,
    OP_IDLE     = 2'b11
  } jtag_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_SHIFT,
    ST_TAIL
  } jtag_state_e;

  localparam int IR_LEN = 3;

  localparam logic [IR_LEN-1:0] INSTR_BYPASS  = 3'b111;
  localparam logic [IR_LEN-1:0] INSTR_IDCODE  = 3'b001;
  localparam logic [IR_LEN-1:0] INSTR_SAMPLE  = 3'b010;
  localparam logic [IR_LEN-1:0] INSTR_PRELOAD = 3'b011;
  localparam logic [IR_LEN-1:0] INSTR_INTEST  = 3'b100;
  localparam logic [IR_LEN-1:0] INSTR_EXTEST  = 3'b101;

  localparam logic [31:0]       IDCODE_WORD = 32'h06C62127;
  localparam logic [IR_LEN-1:0] IR_CAPTURE  = 3'b001;

  // Number of TCK periods in the lead-in TMS walk of each op.
  function automatic int head_periods(jtag_op_e op);
    case (op)
      OP_RESET:    return 6;
      OP_SHIFT_IR: return 4;
      OP_SHIFT_DR: return 3;
      default:     return 0;
    endcase
  endfunction

  // Number of TCK periods in the walk back to Run-Test/Idle.
  function automatic int tail_periods(jtag_op_e op);
    case (op)
      OP_RESET:    return 1;
      OP_SHIFT_IR: return 2;
      OP_SHIFT_DR: return 2;
      default:     return 0;
    endcase
  endfunction

  // TMS value for lead-in period idx: RESET 111111, IR 1100, DR 100.
  function automatic logic head_tms(jtag_op_e op, int idx);
    case (op)
      OP_RESET:    return 1'b1;
      OP_SHIFT_IR: return (idx < 2);
      OP_SHIFT_DR: return (idx == 0);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk cycles low then CLK_DIV high per period. Holds
// phase 0 (low) while disabled so the first enabled cycle is a low cycle.
module jtag_tck_gen
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int PER = 2 * CLK_DIV;
  localparam int CW  = $clog2(PER);

  localparam logic [CW-1:0] PH_RISE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PH_FALL = CW'(PER - 1);

  logic [CW-1:0] ph;

  // Strobes mark the clk edge on which tck goes high (rise) or a new low phase starts (fall).
  assign rise = en && (ph == PH_RISE);
  assign fall = en && (ph == PH_FALL);

  // Phase counter and registered tck.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph  <= '0;
      tck <= 1'b0;
    end else if (!en || fall) begin
      ph  <= '0;
      tck <= 1'b0;
    end else begin
      ph  <= ph + CW'(1);
      tck <= (ph >= PH_RISE);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: accepts one host command at a time, walks TMS through the
// lead-in, shift and tail phases, shifts TDI LSB-first and returns TDO.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = (LEN_W > IDX_W) ? LEN_W : IDX_W;

  jtag_state_e        state;
  jtag_op_e           op;
  logic [MAX_LEN-1:0] sdata;
  logic [MAX_LEN-1:0] cap;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   last;
  logic               rise;
  logic               fall;

  // Index of the final shift period: length clamped into 1..MAX_LEN.
  function automatic logic [CNT_W-1:0] shift_last(logic [LEN_W-1:0] len);
    int n;
    n = int'(len);
    if (n < 1)       n = 1;
    if (n > MAX_LEN) n = MAX_LEN;
    return CNT_W'(n - 1);
  endfunction

  assign cmd_ready = (state == ST_IDLE);

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .tck   (tck),
    .rise  (rise),
    .fall  (fall)
  );

  // Command FSM: advances one TCK period on each fall strobe, captures TDO on rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op    <= jtag_op_e'(cmd_op);
            sdata <= cmd_data;
            cap   <= '0;
            cnt   <= '0;
            tdi   <= 1'b0;
            if (jtag_op_e'(cmd_op) == OP_IDLE) begin
              last <= CNT_W'(cmd_len) - CNT_W'(1);
              tms  <= 1'b0;
              if (cmd_len == '0) begin
                // Zero-length dwell completes immediately with no TCK.
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
              end else begin
                state <= ST_SHIFT;
              end
            end else begin
              // Every TAP-walking op opens with TMS=1.
              last  <= shift_last(cmd_len);
              tms   <= 1'b1;
              state <= ST_HEAD;
            end
          end
        end

        ST_HEAD: begin
          if (fall) begin
            if (cnt == CNT_W'(head_periods(op) - 1)) begin
              cnt <= '0;
              if (op == OP_RESET) begin
                state <= ST_TAIL;
                tms   <= 1'b0;
              end else begin
                state <= ST_SHIFT;
                tms   <= (last == '0);
                tdi   <= sdata[0];
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
              tms <= head_tms(op, int'(cnt) + 1);
            end
          end
        end

        ST_SHIFT: begin
          if (rise && (op != OP_IDLE)) begin
            cap[cnt[IDX_W-1:0]] <= tdo;
          end
          if (fall) begin
            if (cnt == last) begin
              cnt <= '0;
              if (op == OP_IDLE) begin
                state     <= ST_IDLE;
                tms       <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
              end else begin
                // Last shift bit leaves on TMS=1 into Exit1; tail starts with another 1.
                state <= ST_TAIL;
                tms   <= 1'b1;
                tdi   <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
              tms <= ((cnt + CNT_W'(1)) == last) && (op != OP_IDLE);
              if (op != OP_IDLE) begin
                tdi   <= sdata[1];
                sdata <= sdata >> 1;
              end
            end
          end
        end

        ST_TAIL: begin
          if (fall) begin
            if (cnt == CNT_W'(tail_periods(op) - 1)) begin
              state     <= ST_IDLE;
              tms       <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= cap;
            end else begin
              cnt <= cnt + CNT_W'(1);
              tms <= 1'b0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
